// File: rtl/mc_pkg.sv
// mc_pkg: shared states, instruction classes, opcodes and datapath select encodings
package mc_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, ALU_WB, LOAD_WB, HALT} state_t;
  typedef enum logic [3:0] {C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_NOP} iclass_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_JUMP  = 2'b10;
  localparam logic [1:0] PC_RS    = 2'b11;
  localparam logic [1:0] RD_RT    = 2'b00;
  localparam logic [1:0] RD_RD    = 2'b01;
  localparam logic [1:0] RD_RA    = 2'b10;
  localparam logic [1:0] DR_ALU   = 2'b00;
  localparam logic [1:0] DR_DM    = 2'b01;
  localparam logic [1:0] DR_PC4   = 2'b10;
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_OR   = 5'd2;
  localparam logic [4:0] ALU_LUI  = 5'd3;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: classifies the latched opcode/funct into an instruction class
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output iclass_t    o_cls,
  output logic       o_illegal
);
  always_comb begin
    o_cls = C_NOP;
    case (i_op)
      OP_RTYPE: o_cls = i_funct == FN_ADDU ? C_ADDU :
                        i_funct == FN_SUBU ? C_SUBU :
                        i_funct == FN_JR   ? C_JR   : C_NOP;
      OP_J:     o_cls = C_J;
      OP_JAL:   o_cls = C_JAL;
      OP_BEQ:   o_cls = C_BEQ;
      OP_ORI:   o_cls = C_ORI;
      OP_LUI:   o_cls = C_LUI;
      OP_LW:    o_cls = C_LW;
      OP_SW:    o_cls = C_SW;
      default:  o_cls = C_NOP;
    endcase
    o_illegal = o_cls == C_NOP;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM stepping each MIPS instruction through fetch..write-back
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic [1:0] pc_sel,
  output logic [1:0] reg_dst,
  output logic [1:0] data_to_reg,
  output logic       reg_write,
  output logic       alu_src,
  output logic       ext_op,
  output logic [4:0] alu_ctr,
  output logic       mem_read,
  output logic       mem_write,
  output logic       instr_done,
  output logic       halted
);
  state_t  r_state, w_next;
  iclass_t w_cls;
  logic    w_ill;

  mc_decode u_dec (.i_op(op), .i_funct(funct), .o_cls(w_cls), .o_illegal(w_ill));

  always_ff @(posedge clk)
    r_state <= reset ? FETCH : w_next;

  always_comb begin
    w_next      = r_state;
    pc_we       = 1'b0;
    ir_we       = 1'b0;
    pc_sel      = PC_PLUS4;
    reg_dst     = RD_RT;
    data_to_reg = DR_ALU;
    reg_write   = 1'b0;
    alu_src     = 1'b0;
    ext_op      = 1'b0;
    alu_ctr     = ALU_ADD;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    instr_done  = 1'b0;
    halted      = 1'b0;
    case (r_state)
      FETCH: begin
        ir_we  = 1'b1;
        pc_we  = 1'b1;
        w_next = DECODE;
      end
      DECODE: begin
        if (w_cls == C_J || w_cls == C_JAL) begin
          pc_we       = 1'b1;
          pc_sel      = PC_JUMP;
          instr_done  = 1'b1;
          reg_write   = w_cls == C_JAL;
          reg_dst     = w_cls == C_JAL ? RD_RA : RD_RT;
          data_to_reg = w_cls == C_JAL ? DR_PC4 : DR_ALU;
          w_next      = FETCH;
        end else if (w_ill) begin
          instr_done = HALT_ON_ILLEGAL == 0;
          w_next     = HALT_ON_ILLEGAL != 0 ? HALT : FETCH;
        end else
          w_next = EXEC;
      end
      EXEC: begin
        case (w_cls)
          C_ADDU, C_SUBU: begin
            alu_ctr = w_cls == C_SUBU ? ALU_SUB : ALU_ADD;
            w_next  = ALU_WB;
          end
          C_ORI, C_LUI: begin
            alu_src = 1'b1;
            alu_ctr = w_cls == C_LUI ? ALU_LUI : ALU_OR;
            w_next  = ALU_WB;
          end
          C_LW, C_SW: begin
            alu_src = 1'b1;
            ext_op  = 1'b1;
            w_next  = MEM;
          end
          C_BEQ: begin
            alu_ctr    = ALU_SUB;
            pc_sel     = PC_BR;
            pc_we      = zero;
            instr_done = 1'b1;
            w_next     = FETCH;
          end
          C_JR: begin
            pc_sel     = PC_RS;
            pc_we      = 1'b1;
            instr_done = 1'b1;
            w_next     = FETCH;
          end
          default: w_next = FETCH;
        endcase
      end
      MEM: begin
        mem_read   = w_cls == C_LW;
        mem_write  = w_cls == C_SW;
        instr_done = mem_ready && w_cls == C_SW;
        w_next     = !mem_ready ? MEM : w_cls == C_LW ? LOAD_WB : FETCH;
      end
      ALU_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (w_cls == C_ADDU || w_cls == C_SUBU) ? RD_RD : RD_RT;
        instr_done = 1'b1;
        w_next     = FETCH;
      end
      LOAD_WB: begin
        reg_write   = 1'b1;
        data_to_reg = DR_DM;
        instr_done  = 1'b1;
        w_next      = FETCH;
      end
      HALT: halted = 1'b1;
      default: w_next = FETCH;
    endcase
    // the reset cycle must never leak an enable, whatever state is being aborted
    if (reset) begin
      pc_we       = 1'b0;
      ir_we       = 1'b0;
      pc_sel      = PC_PLUS4;
      reg_dst     = RD_RT;
      data_to_reg = DR_ALU;
      reg_write   = 1'b0;
      alu_src     = 1'b0;
      ext_op      = 1'b0;
      alu_ctr     = ALU_ADD;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      instr_done  = 1'b0;
      halted      = 1'b0;
    end
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the MIPS core. It replaces the single-cycle combinational decoder with a state machine. The machine steps each instruction through fetch, decode, execute, memory and write-back cycles, driving the existing PC, IR, register-file, extender, ALU and data-memory enables. The block sits beside the datapath in the `mips` top and reads only the latched instruction register, the ALU zero flag and a data-memory ready handshake.

## Interface
Parameters:
- `HALT_ON_ILLEGAL`, default 1: when 1, an illegal opcode/funct enters HALT; when 0, it is treated as a NOP.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high. Forces state FETCH and all enables to 0 in the reset cycle.
- `op` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, valid in EXEC.
- `mem_ready` in 1: data memory has completed the access this cycle.
- `pc_we` out 1: PC load enable.
- `ir_we` out 1: instruction register load enable.
- `pc_sel` out 2: 00 PC+4, 01 branch target, 10 jump target, 11 rs register.
- `reg_dst` out 2: 00 rt, 01 rd, 10 $31.
- `data_to_reg` out 2: 00 ALU, 01 DM, 10 PC+4.
- `reg_write` out 1: GPR write enable.
- `alu_src` out 1: 0 B register, 1 extended immediate.
- `ext_op` out 1: 0 zero-extend, 1 sign-extend.
- `alu_ctr` out 5: 0 ADD, 1 SUB, 2 OR, 3 LUI (imm<<16); other codes unused.
- `mem_read` out 1: DM read strobe.
- `mem_write` out 1: DM write strobe.
- `instr_done` out 1: one-cycle pulse in the last cycle of each instruction.
- `halted` out 1: high while in HALT.

## Operation
- Supported: addu, subu (R-type, op 0), jr (op 0, funct 08), ori (0D), lui (0F), lw (23), sw (2B), beq (04), j (02), jal (03).
- Outputs are Moore-decoded from the state register and `op`/`funct`. IR is stable from DECODE onward.
- Unlisted enables are 0 in each state; `halted` is 1 only in HALT.
- FETCH: `ir_we`=1, `pc_we`=1, `pc_sel`=00. Next state DECODE.
- DECODE:
  - j: `pc_we`, `pc_sel`=10, done. Next FETCH.
  - jal: the same, plus `reg_write`, `reg_dst`=10, `data_to_reg`=10. PC+4 is still in the datapath PC+4 path. Next FETCH.
  - Illegal: HALT, or FETCH with `instr_done` when the parameter is 0.
  - Otherwise: next EXEC.
- EXEC:
  - R-type: `alu_ctr` ADD/SUB. Next ALU_WB.
  - ori: `alu_src`=1, `ext_op`=0, OR. Next ALU_WB.
  - lui: `alu_src`=1, LUI. Next ALU_WB.
  - lw/sw: `alu_src`=1, `ext_op`=1, ADD. Next MEM.
  - beq: SUB, `pc_sel`=01, `pc_we`=`zero`, done. Next FETCH.
  - jr: `pc_sel`=11, `pc_we`, done. Next FETCH.
- MEM: `mem_read` (lw) or `mem_write` (sw) is held high until `mem_ready`.
  - sw with ready: done. Next FETCH.
  - lw with ready: next LOAD_WB.
  - Not ready: stay in MEM.
- ALU_WB: `reg_write`, `data_to_reg`=00, `reg_dst`=01 (R-type) or 00 (imm). Done. Next FETCH.
- LOAD_WB: `reg_write`, `data_to_reg`=01, `reg_dst`=00. Done. Next FETCH.
- HALT: all enables 0. Leaves only on `reset`.

## Timing
- CPI with zero wait: j/jal 2, beq/jr 3, R/ori/lui/sw 4, lw 5. Each cycle `mem_ready` is low in MEM adds 1.
- Reset value of every output is 0. The first FETCH enables assert in the first cycle after `reset` deasserts.
- `reset` mid-instruction (any state, including a MEM wait) aborts the instruction. No write enable asserts in the reset cycle.
- The MEM strobe must stay asserted and stable until the `mem_ready` cycle. The strobe drops in the cycle after ready.
- `mem_ready` is ignored outside MEM.
- `zero` is sampled only in EXEC for beq.
- `instr_done` is never high in FETCH or HALT.

## Structure
- Package `mc_pkg` holds:
  - the state enum (FETCH, DECODE, EXEC, MEM, ALU_WB, LOAD_WB, HALT);
  - opcode and funct constants;
  - `pc_sel`, `reg_dst`, `data_to_reg` and `alu_ctr` encodings.
- Sub-module `mc_decode`: combinational classification of `op`/`funct` into an instruction class plus an illegal flag. The FSM switches on the class.

## Test plan
- Reset, then addu $3,$1,$2: FETCH, DECODE, EXEC(`alu_ctr`=0), ALU_WB(`reg_write`=1, `reg_dst`=01). `instr_done` in cycle 4.
- lw with `mem_ready` low 3 cycles: `mem_read` high 4 cycles, then LOAD_WB `data_to_reg`=01. Total 8 cycles.
- beq, `zero`=1 then `zero`=0: EXEC `pc_we`=1/`pc_sel`=01 versus `pc_we`=0. Both return to FETCH after 3 cycles.
- jal: DECODE asserts `pc_we`, `pc_sel`=10, `reg_write`, `reg_dst`=10, `data_to_reg`=10. 2 cycles total.
- `reset` asserted during a sw MEM wait: next cycle all outputs 0, state FETCH, `mem_write` never pulses after reset.
- op=3F with `HALT_ON_ILLEGAL`=1: `halted`=1 and stays high for 10 cycles with no enables; `reset` returns to FETCH.
